// File: rtl/input_ctrl.sv
// ---------------------------------------------------------------------------
// input_ctrl
//
// Operator-input stage that sits in front of the CPU's `in` port. The enter
// and clear push-buttons are synchronized and debounced. Each enter press
// captures the switch word into a small FIFO. The oldest entry is presented
// to the CPU through a valid/ack handshake. The block runs on the board
// clock, so debouncing works at full resolution while the slow CPU handshake
// is still honoured.
//
// Ports:
//   clk        board clock (single domain)
//   rst        synchronous, active-high reset
//   btn_enter  raw enter button, active-high, bouncy
//   btn_clear  raw clear button, active-high, bouncy
//   sw         raw switch word (SW_WIDTH bits)
//   ack        CPU consume request; only its rising edge pops an entry
//   data       head entry zero-extended to DATA_WIDTH, or 0 when empty
//   valid      FIFO is non-empty
//   count      number of entries currently held
//   overflow   sticky; set when a press is dropped because the FIFO is full
// ---------------------------------------------------------------------------
module input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int SW_WIDTH        = 4,
   parameter int DATA_WIDTH      = 16,
   parameter int DEPTH           = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      btn_enter,
   input  logic                      btn_clear,
   input  logic [SW_WIDTH-1:0]       sw,
   input  logic                      ack,
   output logic [DATA_WIDTH-1:0]     data,
   output logic                      valid,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   // The counter saturates one short of DEBOUNCE_CYCLES; the next mismatching
   // cycle is the one that toggles the stable level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]    FULL     = CW'(DEPTH);

   // Index 0 is the enter button, index 1 is the clear button.
   logic [1:0]          btn_raw;
   logic [1:0]          btn_s1;
   logic [1:0]          btn_s2;
   logic [1:0]          st;
   logic [1:0]          st_d;
   logic [CNT_W-1:0]    deb_cnt [2];
   logic [SW_WIDTH-1:0] sw_s1;
   logic [SW_WIDTH-1:0] sw_s2;
   logic                ack_d;

   logic [SW_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;

   logic [1:0]          press;
   logic                press_enter;
   logic                press_clear;
   logic                pop_req;
   logic                pop_ok;
   logic                push_ok;
   logic                overflow_set;
   logic [DATA_WIDTH-1:0] head_ext;

   assign btn_raw = {btn_clear, btn_enter};

   // Input conditioning: 2-flop synchronizers, per-button debounce and the
   // registered copies used for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1     <= '0;
         btn_s2     <= '0;
         sw_s1      <= '0;
         sw_s2      <= '0;
         st         <= '0;
         st_d       <= '0;
         ack_d      <= 1'b0;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
      end else begin
         btn_s1 <= btn_raw;
         btn_s2 <= btn_s1;
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
         st_d   <= st;
         ack_d  <= ack;
         for (int i = 0; i < 2; i++) begin
            if (btn_s2[i] == st[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == CNT_LAST) begin
               st[i]      <= ~st[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Press pulses come straight from registered levels, so a push lands one
   // edge after the stable level rises.
   assign press       = st & ~st_d;
   assign press_enter = press[0];
   assign press_clear = press[1];
   assign pop_req     = ack & ~ack_d;

   // A pop on a full FIFO frees the slot a same-edge push needs.
   assign pop_ok       = pop_req && (count != '0);
   assign push_ok      = press_enter && ((count != FULL) || pop_ok);
   assign overflow_set = press_enter && (count == FULL) && !pop_ok;

   // FIFO bookkeeping; clear outranks any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (rst || press_clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (overflow_set) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage has no reset; stale entries are never visible because data is
   // masked by valid.
   always_ff @(posedge clk) begin
      if (!rst && !press_clear && push_ok) begin
         mem[wr_ptr] <= sw_s2;
      end
   end

   always_comb begin
      head_ext                 = '0;
      head_ext[SW_WIDTH-1:0]   = mem[rd_ptr];
   end

   assign valid = (count != '0);
   assign data  = valid ? head_ext : '0;

endmodule
